// File: rtl/mau_pkg.sv
// mau_pkg: shared state/channel types and byte-swap helper for the memory access unit
package mau_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  typedef enum logic {CH_IF, CH_LS} channel_t;
  function automatic logic [63:0] byte_swap(input logic [63:0] d, input int nb);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (i < nb) r[8*i +: 8] = d[8*(nb-1-i) +: 8];
    return r;
  endfunction
endpackage

// File: rtl/mau_if.sv
// mau_if: memory/bus fabric signals between the access unit (master) and memory (slave)
interface mau_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic [NB-1:0] byte_en;
  logic memory_read;
  logic memory_write;
  logic mem_ready;
  logic bus_error;
  modport master (
    output address, data_out, byte_en, memory_read, memory_write,
    input  data_in, mem_ready, bus_error
  );
  modport slave (
    input  address, data_out, byte_en, memory_read, memory_write,
    output data_in, mem_ready, bus_error
  );
endinterface

// File: rtl/mau_lane_mux.sv
// mau_lane_mux: byte-lane enables, store replication, load lane extraction and endian swap
module mau_lane_mux
  import mau_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  logic                        is_byte,
  input  logic                        swap,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W-1:0]           rdata,
  output logic [DATA_W/8-1:0]         byte_en,
  output logic [DATA_W-1:0]           bus_wdata,
  output logic [DATA_W-1:0]           load_data
);
  localparam int NB = DATA_W / 8;
  assign byte_en = is_byte ? NB'(1) << off : '1;
  // byte stores go out on every lane so the memory only needs byte_en to pick one
  assign bus_wdata = is_byte ? {NB{wdata[7:0]}}
                   : swap ? DATA_W'(byte_swap(64'(wdata), NB)) : wdata;
  assign load_data = is_byte ? DATA_W'(rdata[8*off +: 8])
                   : swap ? DATA_W'(byte_swap(64'(rdata), NB)) : rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: round-robin fetch/load-store arbiter driving one bus transaction at a time
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              little_endian_en,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_write,
  input  logic              ls_byte,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ls_rsp_err,
  mau_if.master             mem
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1) + 1;
  state_t st, nxt;
  channel_t ch, last_grant;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr_q, req_addr;
  logic [DATA_W-1:0] wdata_q, rdata_q, bus_wdata, load_data;
  logic [NB-1:0] lane_en;
  logic wr_q, byte_q, err_q, take_ls, accept, misalign, timed_out, in_bus, done;
  assign take_ls   = ls_req_valid && (!if_req_valid || last_grant == CH_IF);
  assign accept    = n_reset && st == IDLE && (ls_req_valid || if_req_valid);
  assign req_addr  = take_ls ? ls_addr : if_addr;
  assign misalign  = (!take_ls || !ls_byte) && req_addr[OB-1:0] != '0;
  assign timed_out = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  assign in_bus    = st == BUS;
  assign done      = mem.mem_ready || timed_out;
  assign if_req_ready = accept && !take_ls;
  assign ls_req_ready = accept && take_ls;
  always_comb begin
    nxt = st;
    if (accept) nxt = misalign ? RESP : BUS;
    else if (in_bus && done) nxt = RESP;
    else if (st == RESP) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      st         <= IDLE;
      ch         <= CH_IF;
      last_grant <= CH_IF;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wr_q       <= 1'b0;
      byte_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      st <= nxt;
      if (accept) begin
        ch         <= take_ls ? CH_LS : CH_IF;
        last_grant <= take_ls ? CH_LS : CH_IF;
        addr_q     <= req_addr;
        wr_q       <= take_ls && ls_write;
        byte_q     <= take_ls && ls_byte;
        wdata_q    <= ls_wdata;
        rdata_q    <= '0;
        err_q      <= misalign;
      end
      if (in_bus) begin
        cnt <= done ? '0 : cnt + CW'(1);
        // ready wins over a timeout landing in the same cycle
        if (mem.mem_ready) begin
          rdata_q <= mem.data_in;
          err_q   <= mem.bus_error;
        end else if (timed_out) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end
  mau_lane_mux #(.DATA_W(DATA_W)) u_lane_mux (
    .off      (addr_q[OB-1:0]),
    .is_byte  (byte_q),
    .swap     (little_endian_en),
    .wdata    (wdata_q),
    .rdata    (rdata_q),
    .byte_en  (lane_en),
    .bus_wdata(bus_wdata),
    .load_data(load_data)
  );
  assign mem.address      = in_bus ? (byte_q ? addr_q : {addr_q[ADDR_W-1:OB], {OB{1'b0}}}) : '0;
  assign mem.byte_en      = in_bus ? lane_en : '0;
  assign mem.data_out     = in_bus && wr_q ? bus_wdata : '0;
  assign mem.memory_read  = in_bus && !wr_q;
  assign mem.memory_write = in_bus && wr_q;
  assign if_rsp_valid = st == RESP && ch == CH_IF;
  assign ls_rsp_valid = st == RESP && ch == CH_LS;
  assign if_rsp_err   = if_rsp_valid && err_q;
  assign ls_rsp_err   = ls_rsp_valid && err_q;
  assign if_rsp_data  = if_rsp_valid && !err_q ? load_data : '0;
  assign ls_rsp_data  = ls_rsp_valid && !err_q && !wr_q ? load_data : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of the memory access unit against a behavioural model
module tb_mem_access_unit;
  logic clk, n_reset, little_endian_en;
  logic if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [31:0] if_addr, if_rsp_data;
  logic ls_req_valid, ls_req_ready, ls_write, ls_byte, ls_rsp_valid, ls_rsp_err;
  logic [31:0] ls_addr, ls_wdata, ls_rsp_data;
  int compared = 0;
  int mismatched = 0;
  mau_if #(.DATA_W(32), .ADDR_W(32)) mem ();
  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .little_endian_en(little_endian_en),
    .if_req_valid    (if_req_valid),
    .if_req_ready    (if_req_ready),
    .if_addr         (if_addr),
    .if_rsp_valid    (if_rsp_valid),
    .if_rsp_data     (if_rsp_data),
    .if_rsp_err      (if_rsp_err),
    .ls_req_valid    (ls_req_valid),
    .ls_req_ready    (ls_req_ready),
    .ls_addr         (ls_addr),
    .ls_write        (ls_write),
    .ls_byte         (ls_byte),
    .ls_wdata        (ls_wdata),
    .ls_rsp_valid    (ls_rsp_valid),
    .ls_rsp_data     (ls_rsp_data),
    .ls_rsp_err      (ls_rsp_err),
    .mem             (mem)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] swap32(input logic [31:0] x);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 4; i++) r |= ((x >> (8 * i)) & 32'hff) << (8 * (3 - i));
    return r;
  endfunction
  // one request on one channel; waits >= 4 means mem_ready never comes (TIMEOUT=4)
  task automatic txn(input bit ls, input logic [31:0] addr, input bit wr, input bit byt,
                     input logic [31:0] wd, input bit le, input int waits, input bit berr,
                     input logic [31:0] din);
    bit mis, to, err;
    logic [31:0] exp_data, exp_be, exp_dout, exp_addr;
    int n;
    mis = !byt && addr[1:0] != 2'd0;
    to = !mis && waits >= 4;
    err = mis || to || berr;
    exp_data = (err || wr) ? 32'h0 : byt ? (din >> (8 * addr[1:0])) & 32'hff : le ? swap32(din) : din;
    exp_be = byt ? 32'(1) << addr[1:0] : 32'hf;
    exp_dout = byt ? 32'(wd[7:0]) * 32'h01010101 : le ? swap32(wd) : wd;
    exp_addr = byt ? addr : addr & ~32'h3;
    @(negedge clk);
    little_endian_en = le;
    if (ls) begin
      ls_req_valid = 1; ls_addr = addr; ls_write = wr; ls_byte = byt; ls_wdata = wd; if_addr = $urandom;
    end else begin
      if_req_valid = 1; if_addr = addr; ls_wdata = $urandom;
    end
    #1;
    n = 0;
    while (!(ls ? ls_req_ready : if_req_ready) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk("req_ready", 32'(ls ? ls_req_ready : if_req_ready), 32'(1));
    chk("req_other_ready", 32'(ls ? if_req_ready : ls_req_ready), 32'(0));
    @(posedge clk); #1;
    if_req_valid = 0; ls_req_valid = 0;
    if (!mis) for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bus_read", 32'(mem.memory_read), 32'(!wr));
      chk("bus_write", 32'(mem.memory_write), 32'(wr));
      chk("bus_no_rsp", 32'(if_rsp_valid | ls_rsp_valid), 32'(0));
      if (c == 0) begin
        chk("bus_addr", mem.address, exp_addr);
        chk("bus_be", 32'(mem.byte_en), exp_be);
        if (wr) chk("bus_dout", mem.data_out, exp_dout);
      end
      mem.mem_ready = c == waits;
      mem.data_in = mem.mem_ready ? din : $urandom;
      mem.bus_error = mem.mem_ready ? berr : 1'($urandom);
      if (mem.mem_ready) break;
    end
    @(negedge clk);
    mem.mem_ready = 0; mem.bus_error = 0;
    chk("rsp_valid", 32'(ls ? ls_rsp_valid : if_rsp_valid), 32'(1));
    chk("rsp_other", 32'(ls ? if_rsp_valid : ls_rsp_valid), 32'(0));
    chk("rsp_err", 32'(ls ? ls_rsp_err : if_rsp_err), 32'(err));
    chk("rsp_data", ls ? ls_rsp_data : if_rsp_data, exp_data);
    chk("rsp_strobes", 32'(mem.memory_read | mem.memory_write), 32'(0));
    @(negedge clk);
    chk("rsp_once", 32'(if_rsp_valid | ls_rsp_valid), 32'(0));
  endtask
  initial begin
    int n;
    clk = 0; n_reset = 0; little_endian_en = 0;
    if_req_valid = 1; ls_req_valid = 1; if_addr = 0; ls_addr = 0;
    ls_write = 0; ls_byte = 0; ls_wdata = 0;
    mem.data_in = 0; mem.mem_ready = 0; mem.bus_error = 0;
    #12;
    chk("reset_if_ready", 32'(if_req_ready), 32'(0));
    chk("reset_ls_ready", 32'(ls_req_ready), 32'(0));
    chk("reset_strobes", 32'({mem.memory_read, mem.memory_write}), 32'(0));
    chk("reset_addr", mem.address, 32'(0));
    chk("reset_be", 32'(mem.byte_en), 32'(0));
    chk("reset_rsp", 32'({if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err}), 32'(0));
    if_req_valid = 0; ls_req_valid = 0;
    @(negedge clk); n_reset = 1;
    txn(0, 32'h100, 0, 0, 32'h0, 1, 0, 0, 32'h78563412);
    txn(1, 32'h203, 1, 1, 32'h000000ab, 0, 3, 0, 32'h0);
    txn(1, 32'h102, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    txn(1, 32'h102, 0, 1, 32'h0, 0, 0, 0, 32'h11223344);
    txn(1, 32'h300, 0, 0, 32'h0, 0, 4, 0, 32'hdeadbeef);
    txn(1, 32'h304, 0, 0, 32'h0, 0, 1, 1, 32'h00001234);
    txn(1, 32'h308, 1, 0, 32'h11223344, 1, 2, 0, 32'h0);
    txn(0, 32'h10a, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    // both channels permanently requesting: grants alternate starting with LS
    @(negedge clk); n_reset = 0;
    #1 n_reset = 1;
    mem.mem_ready = 1; mem.data_in = 32'h5a5a5a5a;
    if_addr = 32'h40; ls_addr = 32'h80; ls_write = 0; ls_byte = 0;
    if_req_valid = 1; ls_req_valid = 1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      #1;
      while (!(if_req_ready || ls_req_ready) && n < 10) begin
        @(negedge clk); n++;
      end
      chk("arb_ls", 32'(ls_req_ready), 32'(k % 2 == 0));
      chk("arb_if", 32'(if_req_ready), 32'(k % 2 == 1));
      @(posedge clk);
    end
    #1 if_req_valid = 0; ls_req_valid = 0;
    repeat (3) @(negedge clk);
    mem.mem_ready = 0;
    // reset in the middle of a waited bus cycle drops the transaction
    ls_req_valid = 1; ls_addr = 32'h400; ls_write = 0; ls_byte = 0;
    #1 chk("rst_pre_ready", 32'(ls_req_ready), 32'(1));
    @(posedge clk); #1 ls_req_valid = 0;
    @(negedge clk);
    chk("rst_pre_read", 32'(mem.memory_read), 32'(1));
    #2 n_reset = 0;
    #1;
    chk("rst_async_read", 32'(mem.memory_read), 32'(0));
    chk("rst_async_addr", mem.address, 32'(0));
    @(negedge clk); n_reset = 1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(if_rsp_valid | ls_rsp_valid), 32'(0));
    end
    txn(1, 32'h404, 0, 0, 32'h0, 0, 1, 0, 32'hcafef00d);
    for (int k = 0; k < 40; k++) begin
      bit ls, wr, byt;
      logic [31:0] a;
      ls = 1'($urandom);
      wr = ls & 1'($urandom);
      byt = ls & 1'($urandom);
      a = $urandom & 32'hffc;
      if (byt || $urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      txn(ls, a, wr, byt, $urandom, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 5) == 0, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised, two-channel memory access unit that replaces the core's single hard-wired address/data_in/data_out/memory_read/memory_write path.
- Arbitrates between an instruction-fetch channel and a load/store channel.
- Runs one bus transaction at a time, with wait-state handshake, timeout, byte/word sizing, alignment checking and endian conversion.
- Sits between the multicycle CPU control FSM and the memory/bus fabric.

Parameters:
DATA_W, 32, bus/data width in bits; multiple of 8, power of two, 16..64.
ADDR_W, 32, address width in bits.
TIMEOUT, 255, max BUS-state cycles waiting for mem_ready before abort; 0 disables the timeout.
NB (derived, localparam), DATA_W/8, byte lanes; OB = log2(NB) address offset bits.

Ports:
clk  in  1  clock
n_reset  in  1  asynchronous, active-low reset
little_endian_en  in  1  1: byte-reverse word data in both directions
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted when valid&ready
if_addr  in  ADDR_W  fetch address (word access)
if_rsp_valid  out  1  one-cycle fetch response strobe
if_rsp_data  out  DATA_W  fetched word
if_rsp_err  out  1  fetch error (with rsp_valid)
ls_req_valid  in  1  load/store request valid
ls_req_ready  out  1  load/store accepted when valid&ready
ls_addr  in  ADDR_W  data address
ls_write  in  1  1 store, 0 load
ls_byte  in  1  1 byte access, 0 word access
ls_wdata  in  DATA_W  store data (byte in [7:0])
ls_rsp_valid  out  1  one-cycle load/store response strobe
ls_rsp_data  out  DATA_W  load data (byte zero-extended); 0 for stores
ls_rsp_err  out  1  load/store error (with rsp_valid)
address  out  ADDR_W  bus address
data_out  out  DATA_W  bus write data
byte_en  out  NB  bus byte-lane enables
memory_read  out  1  bus read strobe
memory_write  out  1  bus write strobe
data_in  in  DATA_W  bus read data
mem_ready  in  1  bus completes the current cycle
bus_error  in  1  error flag, sampled with mem_ready

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 (including both req_ready); last_grant = FETCH; timeout counter 0. Reset mid-transaction drops the transaction; no response is issued afterwards.
- States: IDLE, BUS, RESP.
- IDLE:
  - Grant is combinational. Only ls valid → LS; only if valid → IF.
  - Both valid → the channel not in last_grant (round-robin).
  - Granted channel's req_ready=1; the other is 0. Neither valid → both ready 0.
  - On handshake, latch addr/write/byte/wdata/channel and update last_grant.
  - Next state: BUS; or RESP with err=1 when a word access has addr[OB-1:0]≠0 (misaligned, no bus cycle).
- BUS:
  - Drive address (offset bits forced 0 for word), memory_read=!write, memory_write=write.
  - byte_en all-ones for word; one-hot at addr[OB-1:0] for byte.
  - Store data_out: word = ls_wdata, byte-reversed if little_endian_en; byte = wdata[7:0] replicated on all lanes.
  - mem_ready=1 → capture data_in and bus_error, then go to RESP.
  - Counter increments each BUS cycle without ready. Counter reaches TIMEOUT (TIMEOUT≠0) → abort with err=1, data 0, go to RESP.
  - Strobes held stable until exit; deasserted in RESP.
- RESP:
  - Exactly one cycle of rsp_valid on the owning channel, then IDLE.
  - Load word data = data_in, byte-reversed if little_endian_en.
  - Load byte data = lane addr[OB-1:0] zero-extended.
  - Stores and any error → rsp_data 0. err = bus_error | timeout | misaligned.
- Latency: accept → response = 2 cycles with zero wait states (BUS 1, RESP 1); +1 per wait cycle; misaligned = 1 cycle.
- No new request accepted until the cycle after RESP; req_ready is 0 in BUS/RESP.
- data_in is ignored when mem_ready=0. bus_error without mem_ready is ignored.

Decomposition:
- Package mau_pkg: state enum (IDLE/BUS/RESP), channel encoding (CH_IF/CH_LS), byte_swap function.
- Sub-module mau_lane_mux (combinational): byte_en generation, write replication, read lane extraction/zero-extension, endian swap. The FSM, arbiter and counter stay in the top.

Test Plan:
- Fetch 0x100, little_endian_en=1, data_in=0x78563412, ready on first BUS cycle → if_rsp_data=0x12345678 two cycles after accept, err=0.
- Store byte 0xAB at 0x203, 3 wait states → byte_en=4'b1000, data_out=0xABABABAB, memory_write high 4 cycles, ls_rsp_valid 5 cycles after accept.
- if and ls both valid continuously → grants alternate LS, IF, LS, IF starting with LS after reset.
- Word load at 0x102 → ls_rsp_err=1 next cycle, no memory_read pulse; byte load at 0x102 with data_in=0x11223344 → rsp_data=0x00000022.
- TIMEOUT=4, mem_ready never asserted → strobe deasserted after 4 BUS cycles, rsp_err=1, data 0; mem_ready with bus_error=1 → rsp_err=1.
- n_reset low during BUS wait → strobes/outputs 0 immediately; no rsp_valid after release; next request completes normally.
